// File: rtl/phys_free_list_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | phys_free_list_pkg: shared physical-register definitions          |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
package phys_free_list_pkg;

  localparam int PHYS_REG_IDX_SZ = 6;
  localparam int ZERO_REG        = 0;

  typedef struct packed {
    logic [PHYS_REG_IDX_SZ-1:0] reg_num;
  } preg_t;

endpackage
`default_nettype wire

// File: rtl/phys_free_list_lsb_prio_enc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsb_prio_enc: one-hot and index of the lowest set bit, plus valid |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module lsb_prio_enc #(
  parameter int N = 64,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         valid
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot = vec & (~vec + N'(1));
  assign valid  = |vec;

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/phys_free_list.sv
`default_nettype none
// +------------------------------------------------------------------+
// | phys_free_list: free-preg tracker for rename, retire and rollback |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module phys_free_list
  import phys_free_list_pkg::*;
#(
  parameter int PHYS_REGS = 64,
  parameter int ARCH_REGS = 32,
  localparam int PW = $clog2(PHYS_REGS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 alloc_en,
  output logic [PW-1:0]        alloc_preg,
  output logic                 alloc_valid,
  input  logic                 release_en,
  input  logic [PW-1:0]        release_preg,
  input  logic                 rollback_en,
  input  logic [PHYS_REGS-1:0] rollback_mask,
  output logic [PW:0]          free_count,
  output logic                 empty,
  output logic                 double_free
);

  localparam logic [PW-1:0] C_ZERO_REG = PW'(ZERO_REG);

  logic [PHYS_REGS-1:0] r_free_vec;
  logic [PW:0]          r_free_count;
  logic                 r_empty;
  logic                 r_double_free;

  logic [PHYS_REGS-1:0] w_alloc_onehot;
  logic [PHYS_REGS-1:0] w_alloc_mask;
  logic [PHYS_REGS-1:0] w_release_onehot;
  logic [PHYS_REGS-1:0] w_rollback_bits;
  logic [PHYS_REGS-1:0] w_next_free_vec;
  logic [PW:0]          w_next_count;
  logic                 w_alloc_fire;
  logic                 w_release_fire;
  logic                 w_double_free;
  preg_t                w_release;

  function automatic logic [PW:0] popcount(input logic [PHYS_REGS-1:0] v);
    logic [PW:0] cnt;
    cnt = '0;
    for (int i = 0; i < PHYS_REGS; i++) begin
      cnt = cnt + (PW+1)'(v[i]);
    end
    return cnt;
  endfunction

  lsb_prio_enc #(
    .N (PHYS_REGS)
  ) u_alloc_enc (
    .vec    (r_free_vec),
    .onehot (w_alloc_onehot),
    .idx    (alloc_preg),
    .valid  (alloc_valid)
  );

  assign w_release.reg_num = PHYS_REG_IDX_SZ'(release_preg);

  always_comb begin
    w_alloc_fire     = alloc_en && alloc_valid && !rollback_en;
    w_release_fire   = release_en && (PW'(w_release.reg_num) != C_ZERO_REG);
    w_alloc_mask     = w_alloc_fire ? w_alloc_onehot : '0;
    w_release_onehot = '0;
    w_double_free    = 1'b0;
    if (w_release_fire) begin
      w_release_onehot[release_preg] = 1'b1;
      w_double_free                  = r_free_vec[release_preg];
    end
    // Bit 0 is the hard-wired zero register and must never become free.
    w_rollback_bits  = rollback_en ? (rollback_mask & ~PHYS_REGS'(1)) : '0;
    w_next_free_vec  = (r_free_vec & ~w_alloc_mask) | w_release_onehot | w_rollback_bits;
    w_next_count     = popcount(w_next_free_vec);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        r_free_vec[i] <= (i >= ARCH_REGS);
      end
      r_free_count  <= (PW+1)'(PHYS_REGS - ARCH_REGS);
      r_empty       <= (PHYS_REGS == ARCH_REGS);
      r_double_free <= 1'b0;
    end else begin
      r_free_vec    <= w_next_free_vec;
      r_free_count  <= w_next_count;
      r_empty       <= (w_next_count == '0);
      r_double_free <= r_double_free | w_double_free;
    end
  end

  assign free_count  = r_free_count;
  assign empty       = r_empty;
  assign double_free = r_double_free;

endmodule
`default_nettype wire

// File: tb/tb_phys_free_list.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_phys_free_list: directed self-checking bench for phys_free_list|
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module tb_phys_free_list;

  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int PW        = 6;

  logic                 clock;
  logic                 reset_n;
  logic                 alloc_en;
  logic [PW-1:0]        alloc_preg;
  logic                 alloc_valid;
  logic                 release_en;
  logic [PW-1:0]        release_preg;
  logic                 rollback_en;
  logic [PHYS_REGS-1:0] rollback_mask;
  logic [PW:0]          free_count;
  logic                 empty;
  logic                 double_free;

  int tests_run = 0;
  int tests_failed = 0;

  phys_free_list #(
    .PHYS_REGS (PHYS_REGS),
    .ARCH_REGS (ARCH_REGS)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .alloc_en      (alloc_en),
    .alloc_preg    (alloc_preg),
    .alloc_valid   (alloc_valid),
    .release_en    (release_en),
    .release_preg  (release_preg),
    .rollback_en   (rollback_en),
    .rollback_mask (rollback_mask),
    .free_count    (free_count),
    .empty         (empty),
    .double_free   (double_free)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    alloc_en      = 1'b0;
    release_en    = 1'b0;
    release_preg  = '0;
    rollback_en   = 1'b0;
    rollback_mask = '0;
    step();
    step();
    reset_n = 1'b1;
    #1;

    // Reset state
    check("rst_free_count", 64'(free_count), 64'd32);
    check("rst_alloc_valid", 64'(alloc_valid), 64'd1);
    check("rst_alloc_preg", 64'(alloc_preg), 64'd32);
    check("rst_empty", 64'(empty), 64'd0);
    check("rst_double_free", 64'(double_free), 64'd0);

    // Drain the whole list in order
    alloc_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("drain_tag", 64'(alloc_preg), 64'(32 + i));
      step();
    end
    check("drained_empty", 64'(empty), 64'd1);
    check("drained_valid", 64'(alloc_valid), 64'd0);
    check("drained_preg", 64'(alloc_preg), 64'd0);
    check("drained_count", 64'(free_count), 64'd0);
    step();
    check("alloc_empty_count", 64'(free_count), 64'd0);
    check("alloc_empty_flag", 64'(empty), 64'd1);

    // Release into an empty list with alloc_en held
    release_en   = 1'b1;
    release_preg = 6'd5;
    step();
    release_en = 1'b0;
    alloc_en   = 1'b0;
    check("rel5_preg", 64'(alloc_preg), 64'd5);
    check("rel5_count", 64'(free_count), 64'd1);
    check("rel5_valid", 64'(alloc_valid), 64'd1);
    check("rel5_empty", 64'(empty), 64'd0);
    check("rel5_df", 64'(double_free), 64'd0);
    alloc_en = 1'b1;
    step();
    alloc_en = 1'b0;
    check("take5_count", 64'(free_count), 64'd0);
    check("take5_empty", 64'(empty), 64'd1);

    // Fresh start, allocate 32..35, then rollback with an alloc request
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    alloc_en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("a4_count", 64'(free_count), 64'd28);
    check("a4_preg", 64'(alloc_preg), 64'd36);
    rollback_en   = 1'b1;
    rollback_mask = '0;
    rollback_mask[33] = 1'b1;
    rollback_mask[35] = 1'b1;
    rollback_mask[0]  = 1'b1;
    step();
    rollback_en   = 1'b0;
    rollback_mask = '0;
    alloc_en      = 1'b0;
    check("rb_count", 64'(free_count), 64'd30);
    check("rb_preg", 64'(alloc_preg), 64'd33);
    check("rb_df", 64'(double_free), 64'd0);

    // Release of preg 0 is a no-op
    release_en   = 1'b1;
    release_preg = 6'd0;
    step();
    check("rel0_count", 64'(free_count), 64'd30);
    check("rel0_df", 64'(double_free), 64'd0);
    check("rel0_preg", 64'(alloc_preg), 64'd33);

    // Release plus rollback in one cycle: free 34 and 32
    release_preg  = 6'd34;
    rollback_en   = 1'b1;
    rollback_mask = '0;
    rollback_mask[32] = 1'b1;
    step();
    release_en    = 1'b0;
    rollback_en   = 1'b0;
    rollback_mask = '0;
    check("relrb_count", 64'(free_count), 64'd32);
    check("relrb_preg", 64'(alloc_preg), 64'd32);
    check("relrb_df", 64'(double_free), 64'd0);

    // Allocate 32 while releasing 1 in the same cycle
    alloc_en     = 1'b1;
    release_en   = 1'b1;
    release_preg = 6'd1;
    step();
    alloc_en   = 1'b0;
    release_en = 1'b0;
    check("allocrel_count", 64'(free_count), 64'd32);
    check("allocrel_preg", 64'(alloc_preg), 64'd1);

    // Double free of 40, sticky afterwards
    release_en   = 1'b1;
    release_preg = 6'd40;
    step();
    release_en = 1'b0;
    check("dfree_flag", 64'(double_free), 64'd1);
    check("dfree_count", 64'(free_count), 64'd32);
    step();
    step();
    check("dfree_sticky", 64'(double_free), 64'd1);

    // Asynchronous reset mid-burst
    alloc_en = 1'b1;
    step();
    step();
    check("burst_count", 64'(free_count), 64'd30);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_count", 64'(free_count), 64'd32);
    check("async_preg", 64'(alloc_preg), 64'd32);
    check("async_df", 64'(double_free), 64'd0);
    check("async_empty", 64'(empty), 64'd0);
    alloc_en = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    alloc_en = 1'b1;
    check("resume_preg0", 64'(alloc_preg), 64'd32);
    step();
    alloc_en = 1'b0;
    check("resume_preg1", 64'(alloc_preg), 64'd33);
    check("resume_count", 64'(free_count), 64'd31);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
